cp0_regs: RTL and testbench

- Coprocessor-0 register file for the MIPS pipeline.
- Consumes the 32-bit exception type code produced by the exception-type encoder, together with the faulting PC, the delay-slot flag and the bad address.
- Updates EPC, Cause, Status and BadVAddr, and services MTC0/MFC0.
- Runs the Count/Compare timer; its Status/Cause outputs feed back into the exception-type encoder.

---
 rtl/cp0_defs_pkg.sv | 55 +++++
 rtl/cp0_count_timer.sv | 46 ++++
 rtl/cp0_regs.sv | 130 +++++++++++++
 tb/tb_cp0_regs.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cp0_defs_pkg.sv
// Shared constants for the CP0 register file: register numbers, exception type codes,
// ExcCode values and MTC0 write masks.
package cp0_defs;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCCODE_OV   = 5'h0c;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
  } exc_dec_t;

  // Maps an encoder type code to its ExcCode; ERET and unknown codes are not "valid" here.
  function automatic exc_dec_t decode_exc(input logic [31:0] t);
    exc_dec_t d;
    d.valid = 1'b1;
    d.code  = EXCCODE_INT;
    case (t)
      EXC_INT:  d.code = EXCCODE_INT;
      EXC_ADEL: d.code = EXCCODE_ADEL;
      EXC_ADES: d.code = EXCCODE_ADES;
      EXC_SYS:  d.code = EXCCODE_SYS;
      EXC_BP:   d.code = EXCCODE_BP;
      EXC_RI:   d.code = EXCCODE_RI;
      EXC_OV:   d.code = EXCCODE_OV;
      default:  d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_count_timer.sv
// Count register with prescaler and the Count==Compare timer interrupt latch.
module cp0_count_timer #(
  parameter int CNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  input  logic [31:0] compare,
  output logic [31:0] count,
  output logic        timer_int
);

  localparam int DW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

  logic [DW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DW'(CNT_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      count     <= '0;
      timer_int <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div_q <= '0;
      end else if (tick) begin
        count <= count + 32'd1;
        div_q <= '0;
      end else begin
        div_q <= div_q + 1'b1;
      end

      // A Compare write both acknowledges the interrupt and masks a match in that cycle.
      if (compare_we)
        timer_int <= 1'b0;
      else if (count == compare && compare != 32'd0)
        timer_int <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regs.sv
// MIPS coprocessor-0 register file: exception state capture, MTC0/MFC0, Count/Compare timer.
module cp0_regs
  import cp0_defs::*;
#(
  parameter int          CNT_DIV    = 2,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] except_type_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  logic [31:0] status_d, cause_d, epc_d, badv_d, compare_d;
  logic [31:0] wr_val, rd_cur;
  logic        count_we, compare_we, exc_present;
  exc_dec_t    exc;

  assign count_we    = we_i && (waddr_i == REG_COUNT);
  assign compare_we  = we_i && (waddr_i == REG_COMPARE);
  assign exc_present = (except_type_i != 32'd0);
  assign exc         = decode_exc(except_type_i);

  cp0_count_timer #(.CNT_DIV(CNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (data_i),
    .compare    (compare_o),
    .count      (count_o),
    .timer_int  (timer_int_o)
  );

  // MTC0 is applied first; exception updates below overwrite the fields they own.
  always_comb begin
    status_d  = status_o;
    cause_d   = cause_o;
    epc_d     = epc_o;
    badv_d    = badvaddr_o;
    compare_d = compare_o;

    if (we_i) begin
      case (waddr_i)
        REG_COMPARE: compare_d = data_i;
        REG_STATUS:  status_d  = (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
        REG_CAUSE:   cause_d   = (cause_o & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        REG_EPC:     epc_d     = data_i;
        default:     ;
      endcase
    end

    cause_d[15:10] = {int_i[5] | timer_int_o, int_i[4:0]};
    cause_d[30]    = timer_int_o;

    if (exc.valid) begin
      cause_d[6:2] = exc.code;
      status_d[1]  = 1'b1;
      if (!status_o[1]) begin
        epc_d       = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
      end
      if (except_type_i == EXC_ADEL || except_type_i == EXC_ADES)
        badv_d = bad_addr_i;
    end else if (except_type_i == EXC_ERET) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_o   <= STATUS_RST;
      cause_o    <= '0;
      epc_o      <= '0;
      badvaddr_o <= '0;
      compare_o  <= '0;
    end else begin
      status_o   <= status_d;
      cause_o    <= cause_d;
      epc_o      <= epc_d;
      badvaddr_o <= badv_d;
      compare_o  <= compare_d;
    end
  end

  always_comb begin
    rd_cur = '0;
    case (raddr_i)
      REG_BADVADDR: rd_cur = badvaddr_o;
      REG_COUNT:    rd_cur = count_o;
      REG_COMPARE:  rd_cur = compare_o;
      REG_STATUS:   rd_cur = status_o;
      REG_CAUSE:    rd_cur = cause_o;
      REG_EPC:      rd_cur = epc_o;
      default:      rd_cur = '0;
    endcase
  end

  // Value a register would hold if only the pending MTC0 were applied.
  always_comb begin
    wr_val = '0;
    case (waddr_i)
      REG_BADVADDR: wr_val = badvaddr_o;
      REG_COUNT:    wr_val = data_i;
      REG_COMPARE:  wr_val = data_i;
      REG_STATUS:   wr_val = (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
      REG_CAUSE:    wr_val = (cause_o & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
      REG_EPC:      wr_val = data_i;
      default:      wr_val = '0;
    endcase
  end

  assign data_o = (we_i && waddr_i == raddr_i && !exc_present) ? wr_val : rd_cur;

endmodule

// File: tb/tb_cp0_regs.sv
// Directed, table-driven bench for cp0_regs with hand-computed expectations.
module tb_cp0_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] data_i;
  logic [5:0]  int_i;
  logic [31:0] except_type_i, current_inst_addr_i, bad_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
  logic        timer_int_o;

  int n_cmp = 0;
  int n_err = 0;

  cp0_regs #(.CNT_DIV(2), .STATUS_RST(32'h0040_0000)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .we_i                (we_i),
    .waddr_i             (waddr_i),
    .raddr_i             (raddr_i),
    .data_i              (data_i),
    .int_i               (int_i),
    .except_type_i       (except_type_i),
    .current_inst_addr_i (current_inst_addr_i),
    .is_in_delayslot_i   (is_in_delayslot_i),
    .bad_addr_i          (bad_addr_i),
    .data_o              (data_o),
    .count_o             (count_o),
    .compare_o           (compare_o),
    .status_o            (status_o),
    .cause_o             (cause_o),
    .epc_o               (epc_o),
    .badvaddr_o          (badvaddr_o),
    .timer_int_o         (timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  intr;
    logic [31:0] exc;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [4:0]  raddr;
    logic [31:0] exp_rd;
    logic [31:0] exp_status;
    logic [31:0] exp_cause;
    logic [31:0] exp_epc;
    logic [31:0] exp_badv;
    logic [31:0] exp_cmp;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i = 1'b0; waddr_i = '0; data_i = '0;
    except_type_i = '0; current_inst_addr_i = '0; is_in_delayslot_i = 1'b0; bad_addr_i = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    tick();
    idle();
  endtask

  initial begin
    logic [4:0]  rst_addr [6];
    logic [31:0] rst_exp  [6];

    //         we    waddr  wdata         int       exc     pc            ds    bad           raddr  exp_rd        status        cause         epc           badv          cmp
    tbl[0]  = '{1'b1, 5'd13, 32'hFFFFFFFF, 6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,        5'd13, 32'h00000300, 32'h00400000, 32'h00000300, 32'h00000000, 32'h00000000, 32'h0};
    tbl[1]  = '{1'b1, 5'd8,  32'hDEADBEEF, 6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,        5'd8,  32'h00000000, 32'h00400000, 32'h00000300, 32'h00000000, 32'h00000000, 32'h0};
    tbl[2]  = '{1'b1, 5'd12, 32'hFFFFFFFF, 6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,        5'd12, 32'h0040FF03, 32'h0040FF03, 32'h00000300, 32'h00000000, 32'h00000000, 32'h0};
    tbl[3]  = '{1'b1, 5'd12, 32'h00000000, 6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,        5'd12, 32'h00400000, 32'h00400000, 32'h00000300, 32'h00000000, 32'h00000000, 32'h0};
    tbl[4]  = '{1'b1, 5'd14, 32'h12345678, 6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,        5'd14, 32'h12345678, 32'h00400000, 32'h00000300, 32'h12345678, 32'h00000000, 32'h0};
    tbl[5]  = '{1'b1, 5'd5,  32'hFFFFFFFF, 6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,        5'd5,  32'h00000000, 32'h00400000, 32'h00000300, 32'h12345678, 32'h00000000, 32'h0};
    tbl[6]  = '{1'b0, 5'd0,  32'h00000000, 6'b000010, 32'h0, 32'h0,        1'b0, 32'h0,        5'd13, 32'h00000300, 32'h00400000, 32'h00000B00, 32'h12345678, 32'h00000000, 32'h0};
    tbl[7]  = '{1'b1, 5'd13, 32'h00000000, 6'b100000, 32'h0, 32'h0,        1'b0, 32'h0,        5'd13, 32'h00000800, 32'h00400000, 32'h00008000, 32'h12345678, 32'h00000000, 32'h0};
    tbl[8]  = '{1'b0, 5'd0,  32'h00000000, 6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,        5'd13, 32'h00008000, 32'h00400000, 32'h00000000, 32'h12345678, 32'h00000000, 32'h0};
    tbl[9]  = '{1'b0, 5'd0,  32'h00000000, 6'b000000, 32'h4, 32'hBFC00100, 1'b1, 32'h1233,     5'd14, 32'h12345678, 32'h00400002, 32'h80000010, 32'hBFC000FC, 32'h00001233, 32'h0};
    tbl[10] = '{1'b0, 5'd0,  32'h00000000, 6'b000000, 32'h8, 32'h80000000, 1'b0, 32'h0,        5'd8,  32'h00001233, 32'h00400002, 32'h80000020, 32'hBFC000FC, 32'h00001233, 32'h0};
    tbl[11] = '{1'b0, 5'd0,  32'h00000000, 6'b000000, 32'hE, 32'h0,        1'b0, 32'h0,        5'd12, 32'h00400002, 32'h00400000, 32'h80000020, 32'hBFC000FC, 32'h00001233, 32'h0};
    tbl[12] = '{1'b0, 5'd0,  32'h00000000, 6'b000000, 32'h5, 32'h80001000, 1'b0, 32'h5555,     5'd14, 32'hBFC000FC, 32'h00400002, 32'h00000014, 32'h80001000, 32'h00005555, 32'h0};
    tbl[13] = '{1'b0, 5'd0,  32'h00000000, 6'b000000, 32'hE, 32'h0,        1'b0, 32'h0,        5'd13, 32'h00000014, 32'h00400000, 32'h00000014, 32'h80001000, 32'h00005555, 32'h0};
    tbl[14] = '{1'b0, 5'd0,  32'h00000000, 6'b000000, 32'h3, 32'h80009000, 1'b1, 32'h7777,     5'd11, 32'h00000000, 32'h00400000, 32'h00000014, 32'h80001000, 32'h00005555, 32'h0};
    tbl[15] = '{1'b1, 5'd12, 32'h0000FF01, 6'b000000, 32'hC, 32'h80002000, 1'b0, 32'h0,        5'd12, 32'h00400000, 32'h0040FF03, 32'h00000030, 32'h80002000, 32'h00005555, 32'h0};
    tbl[16] = '{1'b1, 5'd11, 32'h00005000, 6'b000000, 32'hE, 32'h0,        1'b0, 32'h0,        5'd11, 32'h00000000, 32'h0040FF01, 32'h00000030, 32'h80002000, 32'h00005555, 32'h5000};
    tbl[17] = '{1'b0, 5'd0,  32'h00000000, 6'b000000, 32'h1, 32'h80003000, 1'b1, 32'h0,        5'd14, 32'h80002000, 32'h0040FF03, 32'h80000000, 32'h80002FFC, 32'h00005555, 32'h5000};
    tbl[18] = '{1'b1, 5'd11, 32'h00000000, 6'b000000, 32'hE, 32'h0,        1'b0, 32'h0,        5'd13, 32'h80000000, 32'h0040FF01, 32'h80000000, 32'h80002FFC, 32'h00005555, 32'h0};

    rst_addr[0] = 5'd8;  rst_exp[0] = 32'h0;
    rst_addr[1] = 5'd9;  rst_exp[1] = 32'h0;
    rst_addr[2] = 5'd11; rst_exp[2] = 32'h0;
    rst_addr[3] = 5'd12; rst_exp[3] = 32'h00400000;
    rst_addr[4] = 5'd13; rst_exp[4] = 32'h0;
    rst_addr[5] = 5'd14; rst_exp[5] = 32'h0;

    idle();
    rst = 1'b1; int_i = '0; raddr_i = '0;
    tick(); tick();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      raddr_i = rst_addr[i];
      #1;
      chk($sformatf("reset_rd%0d", rst_addr[i]), data_o, rst_exp[i]);
    end
    chk("reset_timer_int", {31'd0, timer_int_o}, 32'd0);
    tick();
    chk("count_after_1", count_o, 32'd0);
    tick();
    chk("count_after_2", count_o, 32'd1);

    for (int i = 0; i < 19; i++) begin
      we_i = tbl[i].we; waddr_i = tbl[i].waddr; data_i = tbl[i].wdata;
      int_i = tbl[i].intr; except_type_i = tbl[i].exc;
      current_inst_addr_i = tbl[i].pc; is_in_delayslot_i = tbl[i].ds;
      bad_addr_i = tbl[i].bad; raddr_i = tbl[i].raddr;
      #1;
      chk($sformatf("v%0d_rd", i), data_o, tbl[i].exp_rd);
      tick();
      idle();
      chk($sformatf("v%0d_status", i), status_o, tbl[i].exp_status);
      chk($sformatf("v%0d_cause", i), cause_o, tbl[i].exp_cause);
      chk($sformatf("v%0d_epc", i), epc_o, tbl[i].exp_epc);
      chk($sformatf("v%0d_badv", i), badvaddr_o, tbl[i].exp_badv);
      chk($sformatf("v%0d_compare", i), compare_o, tbl[i].exp_cmp);
    end
    int_i = '0;

    // Timer: Compare=0x10 then Count=0x0E; Count reaches 0x10 four edges later.
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'h10);
    mtc0(5'd9, 32'h0E);
    chk("cnt_load", count_o, 32'h0E);
    tick(); tick(); tick(); tick();
    chk("cnt_at_cmp", count_o, 32'h10);
    tick();
    chk("timer_set", {31'd0, timer_int_o}, 32'd1);
    tick();
    chk("cause_ti", {30'd0, cause_o[30], cause_o[15]}, 32'd3);
    tick(); tick();
    chk("timer_held", {31'd0, timer_int_o}, 32'd1);
    mtc0(5'd11, 32'h100);
    chk("timer_clr", {31'd0, timer_int_o}, 32'd0);

    // Count write resets the divider and suppresses that cycle's increment.
    mtc0(5'd9, 32'h50);
    chk("cnt_wr", count_o, 32'h50);
    tick();
    chk("cnt_wr_hold", count_o, 32'h50);
    tick();
    chk("cnt_wr_inc", count_o, 32'h51);

    // Reset overrides a concurrent write and exception.
    rst = 1'b1; we_i = 1'b1; waddr_i = 5'd12; data_i = 32'hFFFFFFFF;
    except_type_i = 32'h4; current_inst_addr_i = 32'h80000100; bad_addr_i = 32'h99;
    tick();
    rst = 1'b0; idle();
    chk("mid_rst_status", status_o, 32'h00400000);
    chk("mid_rst_epc", epc_o, 32'h0);
    chk("mid_rst_badv", badvaddr_o, 32'h0);
    chk("mid_rst_count", count_o, 32'h0);
    chk("mid_rst_compare", compare_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
